// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and named register indices used by
// the register file, ALU and decoder.
package cpu_pkg;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;
endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: zero-register check, optional
// same-cycle write bypass, and the final output mux.
module rf_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] stored,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);
    always_comb begin
        rd = stored;
        // Reset and register 0 both take priority over the in-flight write.
        if (!rst || (ra == '0)) begin
            rd = '0;
        end else if (BYPASS && we && (wa == ra)) begin
            rd = wd;
        end
    end
endmodule

// File: rtl/reg_file.sv
// General-purpose register file: two bypassable read ports for the ALU, one
// synchronous write port, and a non-bypassed debug read port.
module reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rf_ra1,
    input  logic [ADDR_W-1:0] rf_ra2,
    output logic [DATA_W-1:0] rf_rd1,
    output logic [DATA_W-1:0] rf_rd2,
    input  logic              rf_we,
    input  logic [ADDR_W-1:0] rf_wa,
    input  logic [DATA_W-1:0] rf_wd,
    input  logic [ADDR_W-1:0] dbg_ra,
    output logic [DATA_W-1:0] dbg_rd
);
    localparam int DEPTH = 2 ** ADDR_W;

    // Register 0 has no storage; the read ports synthesize its zero.
    logic [DATA_W-1:0] regs [1:DEPTH-1];
    logic [DATA_W-1:0] stored1, stored2, stored_dbg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (rf_we && (rf_wa != '0)) begin
            regs[rf_wa] <= rf_wd;
        end
    end

    always_comb begin
        stored1    = '0;
        stored2    = '0;
        stored_dbg = '0;
        if (rf_ra1 != '0) stored1    = regs[rf_ra1];
        if (rf_ra2 != '0) stored2    = regs[rf_ra2];
        if (dbg_ra != '0) stored_dbg = regs[dbg_ra];
    end

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port1 (
        .rst(rst), .ra(rf_ra1), .stored(stored1),
        .we(rf_we), .wa(rf_wa), .wd(rf_wd), .rd(rf_rd1)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port2 (
        .rst(rst), .ra(rf_ra2), .stored(stored2),
        .we(rf_we), .wa(rf_wa), .wd(rf_wd), .rd(rf_rd2)
    );

    // Debug view shows committed state only, so its bypass is tied off.
    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_port_dbg (
        .rst(rst), .ra(dbg_ra), .stored(stored_dbg),
        .we(1'b0), .wa(rf_wa), .wd(rf_wd), .rd(dbg_rd)
    );
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: a bypass instance and a no-bypass instance share inputs
// and are compared against an array model of the architectural registers.
module tb_reg_file;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  ra1, ra2, wa, dbg_ra;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd1_b, rd2_b, dbg_b;
    logic [31:0] rd1_n, rd2_n, dbg_n;

    logic [31:0] mem [32];
    int          errors = 0;
    int          checks = 0;

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .rf_ra1(ra1), .rf_ra2(ra2), .rf_rd1(rd1_b),
        .rf_rd2(rd2_b), .rf_we(we), .rf_wa(wa), .rf_wd(wd),
        .dbg_ra(dbg_ra), .dbg_rd(dbg_b)
    );

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .rf_ra1(ra1), .rf_ra2(ra2), .rf_rd1(rd1_n),
        .rf_rd2(rd2_n), .rf_we(we), .rf_wa(wa), .rf_wd(wd),
        .dbg_ra(dbg_ra), .dbg_rd(dbg_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit byp);
        if (!rst || a == 5'd0) return 32'h0;
        if (byp && we && wa == a) return wd;
        return mem[a];
    endfunction

    task automatic check_all(input string tag);
        check({tag, " rd1"},     rd1_b, model_read(ra1, 1'b1));
        check({tag, " rd2"},     rd2_b, model_read(ra2, 1'b1));
        check({tag, " dbg"},     dbg_b, model_read(dbg_ra, 1'b0));
        check({tag, " nb_rd1"},  rd1_n, model_read(ra1, 1'b0));
        check({tag, " nb_rd2"},  rd2_n, model_read(ra2, 1'b0));
        check({tag, " nb_dbg"},  dbg_n, model_read(dbg_ra, 1'b0));
    endtask

    // Model commits the architectural write, then the clock edge happens.
    task automatic tick();
        if (rst && we && wa != 5'd0) mem[wa] = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; wa = a; wd = d;
        tick();
        we = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] alu_res;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0;
        ra1 = 5'd5; ra2 = 5'd7; dbg_ra = 5'd31;
        #1;
        check("reset rd1", rd1_b, 32'h0);
        check("reset rd2", rd2_b, 32'h0);
        check("reset dbg", dbg_b, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Write immediately after release, then an unaligned reset pulse.
        write_reg(5'd5, 32'hDEAD_BEEF);
        dbg_ra = 5'd5; ra1 = 5'd5;
        #1;
        check("r5 written", dbg_b, 32'hDEAD_BEEF);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        #1;
        check("rd1 during reset", rd1_b, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("r5 after reset", rd1_b, 32'h0);
        check("r5 dbg after reset", dbg_b, 32'h0);

        // Same-cycle bypass on both ports; no-bypass instance shows old value.
        @(negedge clk);
        we = 1'b1; wa = 5'd7; wd = 32'h12; ra1 = 5'd7; ra2 = 5'd7; dbg_ra = 5'd7;
        #1;
        check("bypass rd1", rd1_b, 32'h12);
        check("bypass rd2", rd2_b, 32'h12);
        check("no bypass rd1", rd1_n, 32'h0);
        check("dbg not bypassed", dbg_b, 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("r7 rd1 after", rd1_b, 32'h12);
        check("r7 rd2 after", rd2_b, 32'h12);
        check("r7 nb rd1 after", rd1_n, 32'h12);

        // Register 0 ignores writes and reads as zero.
        @(negedge clk);
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; dbg_ra = 5'd0;
        #1;
        check("r0 same cycle", rd1_b, 32'h0);
        check("r0 dbg", dbg_b, 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("r0 after", rd1_b, 32'h0);

        // Read-during-write with and without bypass.
        write_reg(5'd3, 32'h1);
        @(negedge clk);
        we = 1'b1; wa = 5'd3; wd = 32'h2; ra1 = 5'd3; dbg_ra = 5'd3;
        #1;
        check("nb r3 before edge", rd1_n, 32'h1);
        check("b r3 before edge", rd1_b, 32'h2);
        check("dbg r3 before edge", dbg_b, 32'h1);
        tick();
        we = 1'b0;
        #1;
        check("nb r3 after edge", rd1_n, 32'h2);
        check("dbg r3 after edge", dbg_b, 32'h2);

        // Reset held across an edge with a pending write.
        @(negedge clk);
        we = 1'b1; wa = 5'd9; wd = 32'hA5A5_A5A5; rst = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        tick();
        @(negedge clk);
        we = 1'b0; rst = 1'b1; ra1 = 5'd9; dbg_ra = 5'd9;
        #1;
        check("r9 reset wins", rd1_b, 32'h0);
        check("r9 dbg reset wins", dbg_b, 32'h0);

        // Named registers.
        write_reg(REG_SP, 32'h0000_7FF0);
        write_reg(REG_RA, 32'h0040_0024);
        ra1 = REG_SP; ra2 = REG_RA;
        #1;
        check("sp", rd1_b, 32'h0000_7FF0);
        check("ra", rd2_b, 32'h0040_0024);

        // ALU subtract smoke (alu_ct 0110): operands come from the two ports.
        write_reg(5'd1, 32'd10);
        write_reg(5'd2, 32'd3);
        ra1 = 5'd1; ra2 = 5'd2;
        #1;
        alu_res = rd1_b - rd2_b;
        check("alu sub res", alu_res, 32'd7);
        check("alu sub zero", {31'h0, alu_res == 32'h0}, 32'd0);
        write_reg(5'd2, 32'd10);
        alu_res = rd1_b - rd2_b;
        check("alu zero res", alu_res, 32'd0);
        check("alu zero flag", {31'h0, alu_res == 32'h0}, 32'd1);

        // Randomized traffic against the model, including occasional resets.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            we     = ($urandom_range(0, 3) != 0);
            wa     = 5'($urandom_range(0, 31));
            wd     = $urandom;
            ra1    = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2    = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            dbg_ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rst    = ($urandom_range(0, 99) != 0);
            if (!rst) for (int i = 0; i < 32; i++) mem[i] = 32'h0;
            #1;
            check_all("rand pre");
            tick();
            check_all("rand post");
        end
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
